hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL provide the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_RegisterRs1  in  5  rs1 of the instruction in the ID stage.
- IF_ID_RegisterRs2  in  5  rs2 of the instruction in the ID stage.
- ID_EX_RegisterRd  in  5  rd of the instruction in the EX stage.
- ID_EX_RegWrite  in  1  the EX-stage instruction writes the register file.
- ID_EX_MemRead  in  1  the EX-stage instruction is a load.
- EX_MEM_RegisterRd  in  5  rd of the instruction in the MEM stage.
- EX_MEM_RegWrite  in  1  the MEM-stage instruction writes the register file.
- BranchTaken  in  1  a branch or jump in EX redirects the PC.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- ID_EX_Bubble  out  1  zero the ID/EX control fields (inserts a NOP).
- IF_ID_Flush  out  1  clear IF/ID to a NOP.
- StallCount  out  16  saturating count of stall cycles.

Function
REQ-002 The controller SHALL be a Moore FSM with three states, RUN, STALL and FLUSH, plus a 2-bit down-counter stall_left.
REQ-003 A hazard SHALL be declared for a producer only when all of these hold: its RegWrite is 1, its rd is not 0, and its rd equals IF_ID_RegisterRs1 or IF_ID_RegisterRs2.
REQ-004 With forwarding enabled, a hazard SHALL be raised only for a load-use case: ID_EX_MemRead=1 and the hazard condition holds against ID_EX. The required stall is 1 cycle.
REQ-005 In RUN with BranchTaken=1, the next state SHALL be FLUSH, regardless of any hazard.
REQ-006 In RUN with no branch and a hazard, the next state SHALL be STALL, and stall_left SHALL be loaded with the required count minus 1.
REQ-007 In RUN with neither a branch nor a hazard, the FSM SHALL remain in RUN.
REQ-008 STALL outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
REQ-009 In STALL, if stall_left is not 0 it SHALL decrement and the FSM SHALL stay in STALL; if stall_left is 0 the FSM SHALL return to RUN.
REQ-010 In STALL with BranchTaken=1, the next state SHALL be FLUSH and stall_left SHALL be cleared; the branch wins.
REQ-011 FLUSH outputs: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1. FLUSH lasts exactly 1 cycle, then the FSM goes to RUN.
REQ-012 A BranchTaken=1 seen while in FLUSH SHALL re-enter FLUSH.
REQ-013 RUN outputs: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
REQ-014 Outputs SHALL be decoded from the registered state only, so the first stall cycle appears one cycle after the hazard is sampled.
- To cover the hazard cycle itself, RUN SHALL also combinationally force PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 whenever a hazard is present and BranchTaken=0.
- The hazard cycle therefore counts as stall cycle 1.
REQ-015 StallCount SHALL increment by 1 in every cycle where PCWrite=0, and SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-016 While rst_n=0, the block SHALL hold: state=RUN, stall_left=0, StallCount=0, PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
REQ-017 Assertion of rst_n during STALL or FLUSH SHALL abort the operation immediately, without waiting for a clock edge.
REQ-018 After deassertion, the first rising edge SHALL evaluate from RUN.

Configuration
REQ-019 The macro HAZARD_FWD_EN SHALL select the hazard policy.
- Defined: the forwarding policy of REQ-004 applies.
- Undefined: a hazard against EX_MEM requires 1 stall cycle, and a hazard against ID_EX requires 2 stall cycles. ID_EX takes precedence if both match.
- In both cases, a same-cycle write-back followed by a register-file read needs no stall.

Structure
REQ-020 A shared package hazard_pkg SHALL hold:
- the state encoding RUN=2'b00, STALL=2'b01, FLUSH=2'b10;
- the constant ZERO_REG=5'd0;
- the constant STALL_CNT_MAX=16'hFFFF.
REQ-021 The hazard comparison of REQ-003 SHALL live in one sub-module, hazard_match, instantiated once per producer (ID_EX and EX_MEM).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load-use, forwarding on: ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_RegisterRs1=5 -> exactly 1 cycle with PCWrite=0 and ID_EX_Bubble=1; StallCount becomes 1.
- rd=0: same stimulus with ID_EX_RegisterRd=0 -> no stall; StallCount stays 0.
- Branch during stall, forwarding off: ID_EX hazard, then BranchTaken=1 in the next cycle -> FLUSH with IF_ID_Flush=1 for 1 cycle, then RUN.
- Forwarding off, two-cycle stall: ID_EX_RegWrite=1, ID_EX_RegisterRd=7, IF_ID_RegisterRs2=7 -> PCWrite=0 for 2 cycles.
- Saturation: preload StallCount to 16'hFFFE, apply 3 stall cycles -> StallCount reads 16'hFFFF.
- Mid-stall reset: pulse rst_n low between clock edges during STALL -> outputs return to reset values immediately; state=RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN   = 2'b00;
  localparam state_t STALL = 2'b01;
  localparam state_t FLUSH = 2'b10;

  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_match.sv
// RAW hazard detector for a single producer stage against the ID-stage sources.
module hazard_match
  import hazard_pkg::*;
(
  input  logic       reg_write_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       match_o
);

  assign match_o = reg_write_i && (rd_i != ZERO_REG) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush controller (RUN/STALL/FLUSH) with saturating stall counter.
// Define HAZARD_FWD_EN for the forwarding policy (load-use stalls only).
module hazard_controller
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RegisterRs1,
  input  logic [4:0]  IF_ID_RegisterRs2,
  input  logic [4:0]  ID_EX_RegisterRd,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  EX_MEM_RegisterRd,
  input  logic        EX_MEM_RegWrite,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic [15:0] StallCount
);

  state_t      state_q, state_d;
  logic [1:0]  stall_left_q, stall_left_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       id_ex_match, ex_mem_match;
  logic       hazard;
  logic [1:0] need_cycles;
  logic       hazard_stall;

  hazard_match u_match_id_ex (
    .reg_write_i (ID_EX_RegWrite),
    .rd_i        (ID_EX_RegisterRd),
    .rs1_i       (IF_ID_RegisterRs1),
    .rs2_i       (IF_ID_RegisterRs2),
    .match_o     (id_ex_match)
  );

  hazard_match u_match_ex_mem (
    .reg_write_i (EX_MEM_RegWrite),
    .rd_i        (EX_MEM_RegisterRd),
    .rs1_i       (IF_ID_RegisterRs1),
    .rs2_i       (IF_ID_RegisterRs2),
    .match_o     (ex_mem_match)
  );

  // MEM/WB needs no check: the register file writes before it reads in the same cycle.
`ifdef HAZARD_FWD_EN
  logic unused_ex_mem_match;
  assign unused_ex_mem_match = ex_mem_match;
  assign hazard      = id_ex_match && ID_EX_MemRead;
  assign need_cycles = 2'd1;
`else
  logic unused_mem_read;
  assign unused_mem_read = ID_EX_MemRead;
  assign hazard      = id_ex_match || ex_mem_match;
  assign need_cycles = id_ex_match ? 2'd2 : 2'd1;
`endif

  // Gated by rst_n so outputs hold their reset values while reset is asserted.
  assign hazard_stall = hazard && !BranchTaken && rst_n;

  // stall_left holds the STALL-state cycles still owed; the hazard cycle itself is cycle 1.
  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    case (state_q)
      RUN: begin
        if (BranchTaken) begin
          state_d      = FLUSH;
          stall_left_d = 2'd0;
        end else if (hazard) begin
          stall_left_d = need_cycles - 2'd1;
          state_d      = (need_cycles > 2'd1) ? STALL : RUN;
        end
      end
      STALL: begin
        if (BranchTaken) begin
          state_d      = FLUSH;
          stall_left_d = 2'd0;
        end else if (stall_left_q > 2'd1) begin
          stall_left_d = stall_left_q - 2'd1;
        end else begin
          state_d      = RUN;
          stall_left_d = 2'd0;
        end
      end
      FLUSH: begin
        state_d      = BranchTaken ? FLUSH : RUN;
        stall_left_d = 2'd0;
      end
      default: begin
        state_d      = RUN;
        stall_left_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard_stall) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
      STALL: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
      FLUSH: begin
        ID_EX_Bubble = 1'b1;
        IF_ID_Flush  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_left_q <= 2'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
